// File: rtl/a2g_lut_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// a2g_lut_dump_ctrl_if
//
// Purpose: bundles the LUT BRAM read port and the outgoing valid/ready word
// stream of the LUT dump sequencer.
//
// Parameters:
//   ADDR_W      - LUT address width
//   DATA_W      - LUT word / stream data width
//
// Signals:
//   lut_rd_en   - LUT read strobe (sequencer -> BRAM)
//   lut_addr    - LUT read address (sequencer -> BRAM)
//   lut_rd_data - LUT read data, fixed latency after lut_rd_en (BRAM -> sequencer)
//   out_data    - stream data (sequencer -> sink)
//   out_valid   - stream valid (sequencer -> sink)
//   out_last    - marks the word read from the final LUT address (sequencer -> sink)
//   out_ready   - stream ready (sink -> sequencer)
//
// Modports: master = sequencer side, slave = BRAM/sink side.
// -----------------------------------------------------------------------------
interface a2g_lut_dump_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              lut_rd_en;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output lut_rd_en,
    output lut_addr,
    input  lut_rd_data,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  lut_rd_en,
    input  lut_addr,
    output lut_rd_data,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/a2g_lut_dump_ctrl.sv
// -----------------------------------------------------------------------------
// a2g_lut_dump_ctrl
//
// Purpose: on a rising edge of the software trigger, walks every LUT address
// in order, reads the LUT BRAM and streams each word out over a valid/ready
// handshake. Read data lands in a 4-entry FIFO; reads are only issued while
// credit remains, so backpressure can never overflow the FIFO or lose a word.
//
// Parameters:
//   ADDR_W  - LUT address width (depth = 2**ADDR_W)
//   DATA_W  - LUT / stream data width
//   RD_LAT  - fixed LUT BRAM read latency in cycles, legal range 1..3
//
// Ports:
//   user_clk      - single clock for all logic
//   user_rst      - asynchronous active-high reset
//   dump_trig     - software trigger level; a rising edge requests a dump
//   bus           - master side of a2g_lut_dump_ctrl_if (LUT port + stream)
//   sending_data  - status word: bit 0 = busy; upper bits see below
//
// Optional feature (macro A2G_LUT_DUMP_CNT_EN):
//   defined   - sending_data[31:16] counts completed dumps (wraps, cleared by
//               reset), sending_data[15:1] = 0
//   undefined - sending_data[31:1] = 0 and no counter is built
// -----------------------------------------------------------------------------
module a2g_lut_dump_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                dump_trig,
  a2g_lut_dump_ctrl_if.master bus,
  output logic [31:0]         sending_data
);

  localparam int                FIFO_DEPTH = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  logic              trig_q;
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              issue;
  logic              issue_last;

  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_l;
  logic              push;
  logic              push_last;
  logic [2:0]        inflight;

  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;
  logic                  fifo_empty;
  logic                  pop;
  logic                  head_last;
  logic [3:0]            credit;

  // Trigger edge register; edges outside IDLE are simply dropped.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= dump_trig;
    end
  end

  assign start = dump_trig && !trig_q && (state == IDLE);
  assign busy  = (state != IDLE);

  // Credit counts the popped slot of this cycle, so a read can be issued in
  // the same cycle a word leaves a full pipeline.
  assign credit = 4'd4 + {3'd0, pop} - {1'b0, fifo_count} - {1'b0, inflight};

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        issue = (credit != 4'd0);
        if (issue && (addr == LAST_ADDR)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign issue_last = issue && (addr == LAST_ADDR);

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      addr <= '0;
    end else if (start) begin
      addr <= '0;
    end else if (issue) begin
      addr <= addr + 1'b1;
    end
  end

  // Return-path tags ride alongside the BRAM latency; the oldest stage lines
  // up with the cycle in which lut_rd_data is valid.
  generate
    if (RD_LAT == 1) begin : g_tag_single
      always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
          tag_v <= '0;
          tag_l <= '0;
        end else begin
          tag_v <= issue;
          tag_l <= issue_last;
        end
      end
    end else begin : g_tag_shift
      always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
          tag_v <= '0;
          tag_l <= '0;
        end else begin
          tag_v <= {tag_v[RD_LAT-2:0], issue};
          tag_l <= {tag_l[RD_LAT-2:0], issue_last};
        end
      end
    end
  endgenerate

  assign push      = tag_v[RD_LAT-1];
  assign push_last = tag_l[RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {2'd0, tag_v[i]};
    end
  end

  assign fifo_empty = (fifo_count == 3'd0);
  assign pop        = !fifo_empty && bus.out_ready;
  assign head_last  = fifo_last[rd_ptr];

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_count <= fifo_count + {2'd0, push} - {2'd0, pop};
    end
  end

  // Storage is not reset: empty-FIFO outputs are gated to zero below.
  always_ff @(posedge user_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.lut_rd_data;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  assign bus.lut_rd_en = issue;
  assign bus.lut_addr  = addr;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign bus.out_last  = !fifo_empty && head_last;

`ifdef A2G_LUT_DUMP_CNT_EN
  logic [15:0] dump_cnt;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      dump_cnt <= '0;
    end else if (pop && head_last) begin
      dump_cnt <= dump_cnt + 16'd1;
    end
  end

  assign sending_data = {dump_cnt, 15'd0, busy};
`else
  assign sending_data = {31'd0, busy};
`endif

endmodule

// File: tb/tb_a2g_lut_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_a2g_lut_dump_ctrl
//
// Three sequencer instances (RD_LAT = 1, 2, 3, ADDR_W = 4) share trigger,
// ready and reset. Each lane has its own LUT model (LUT[i] = 0x100 + 3*i)
// and a negedge monitor that pops expected words from the lane queue filled
// by applyStimulus. Honors A2G_LUT_DUMP_CNT_EN for the status word checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_a2g_lut_dump_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic user_clk = 1'b0;
  logic user_rst;
  logic dump_trig;
  logic out_ready;
  int   cyc        = 0;
  int   tests      = 0;
  int   fails      = 0;
  int   ready_mode = 0;
  int   trig_cyc   = 0;

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Ready pattern: always high, or high one cycle in three.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge user_clk);
      #1;
      out_ready = (ready_mode == 0) || (cyc % 3 == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = g + 1;

    a2g_lut_dump_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic [31:0]       sending_data;
    logic [DATA_W-1:0] rd_pipe [LAT];
    logic [32:0]       exp_q [$];
    logic [32:0]       stall_word;
    logic [32:0]       exp_word;
    int hs_count        = 0;
    int issued          = 0;
    int popped          = 0;
    int dumps_done      = 0;
    int first_valid_cyc = -1;
    int last_hs_cyc     = -1;
    int rise_cyc        = -1;
    bit seen_valid      = 1'b0;
    bit prev_busy       = 1'b0;
    bit stalled         = 1'b0;
    bit hs;

    a2g_lut_dump_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT)) dut (
      .user_clk     (user_clk),
      .user_rst     (user_rst),
      .dump_trig    (dump_trig),
      .bus          (bus.master),
      .sending_data (sending_data)
    );

    assign bus.out_ready   = out_ready;
    assign bus.lut_rd_data = rd_pipe[LAT-1];

    // LUT BRAM model: data valid LAT cycles after the strobe, junk otherwise.
    always @(posedge user_clk) begin
      rd_pipe[0] <= bus.lut_rd_en ? (32'h100 + 32'd3 * {28'd0, bus.lut_addr}) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Monitor: scoreboard pops, hold-stable, credit, address order, busy, counter.
    always @(negedge user_clk) begin
      if (user_rst) begin
        issued     = 0;
        popped     = 0;
        dumps_done = 0;
        stalled    = 1'b0;
        prev_busy  = 1'b0;
      end else begin
`ifdef A2G_LUT_DUMP_CNT_EN
        checkOutput("dump_cnt", 64'(sending_data[31:16]), 64'(dumps_done[15:0]));
`else
        checkOutput("status_upper_zero", 64'(sending_data[31:1]), 64'd0);
`endif
        if (!prev_busy && sending_data[0]) begin
          rise_cyc   = cyc;
          seen_valid = 1'b0;
        end
        if (prev_busy && !sending_data[0]) begin
          checkOutput("busy_fall", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        prev_busy = sending_data[0];

        if (stalled) begin
          checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
          checkOutput("hold_word", 64'({bus.out_last, bus.out_data}), 64'(stall_word));
        end
        stalled = 1'b0;

        if (bus.out_valid && !seen_valid) begin
          seen_valid      = 1'b1;
          first_valid_cyc = cyc;
        end

        hs = bus.out_valid && out_ready;
        if (bus.lut_rd_en) begin
          checkOutput("credit_ok", 64'((issued - popped - int'(hs)) < 4), 64'd1);
          checkOutput("rd_addr", 64'(bus.lut_addr), 64'(issued % DEPTH));
          issued++;
        end

        if (hs) begin
          checkOutput("expect_avail", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            exp_word = exp_q.pop_front();
            checkOutput("word", 64'({bus.out_last, bus.out_data}), 64'(exp_word));
          end
          popped++;
          hs_count++;
          if (bus.out_last) begin
            last_hs_cyc = cyc;
            dumps_done++;
          end
        end else if (bus.out_valid) begin
          stalled    = 1'b1;
          stall_word = {bus.out_last, bus.out_data};
        end
      end
    end
  end

  task automatic applyStimulus(input bit level, input bit expect_dump);
    logic [32:0] w;
    @(posedge user_clk);
    #1;
    dump_trig = level;
    trig_cyc  = cyc;
    if (expect_dump) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = {(i == DEPTH - 1), 32'h100 + 32'(3 * i)};
        lane[0].exp_q.push_back(w);
        lane[1].exp_q.push_back(w);
        lane[2].exp_q.push_back(w);
      end
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge user_clk);
      #2;
      done = (lane[0].exp_q.size() == 0) && (lane[1].exp_q.size() == 0) &&
             (lane[2].exp_q.size() == 0) && !lane[0].sending_data[0] &&
             !lane[1].sending_data[0] && !lane[2].sending_data[0];
    end
    checkOutput(name, 64'(done), 64'd1);
  endtask

  // Timing with out_ready held high: rise N+1, first valid N+2+LAT, last N+1+LAT+DEPTH.
  task automatic checkTiming(input int n);
    checkOutput("rise_lat1",  64'(lane[0].rise_cyc),        64'(n + 1));
    checkOutput("first_lat1", 64'(lane[0].first_valid_cyc), 64'(n + 3));
    checkOutput("last_lat1",  64'(lane[0].last_hs_cyc),     64'(n + 2 + DEPTH));
    checkOutput("rise_lat2",  64'(lane[1].rise_cyc),        64'(n + 1));
    checkOutput("first_lat2", 64'(lane[1].first_valid_cyc), 64'(n + 4));
    checkOutput("last_lat2",  64'(lane[1].last_hs_cyc),     64'(n + 19));
    checkOutput("rise_lat3",  64'(lane[2].rise_cyc),        64'(n + 1));
    checkOutput("first_lat3", 64'(lane[2].first_valid_cyc), 64'(n + 5));
    checkOutput("last_lat3",  64'(lane[2].last_hs_cyc),     64'(n + 4 + DEPTH));
  endtask

  task automatic checkResetAll(input string name);
    checkOutput({name, "_out_lat1"}, 64'({lane[0].bus.lut_rd_en, lane[0].bus.lut_addr, lane[0].bus.out_valid,
                                          lane[0].bus.out_last, lane[0].bus.out_data}), 64'd0);
    checkOutput({name, "_sd_lat1"}, 64'(lane[0].sending_data), 64'd0);
    checkOutput({name, "_out_lat2"}, 64'({lane[1].bus.lut_rd_en, lane[1].bus.lut_addr, lane[1].bus.out_valid,
                                          lane[1].bus.out_last, lane[1].bus.out_data}), 64'd0);
    checkOutput({name, "_sd_lat2"}, 64'(lane[1].sending_data), 64'd0);
    checkOutput({name, "_out_lat3"}, 64'({lane[2].bus.lut_rd_en, lane[2].bus.lut_addr, lane[2].bus.out_valid,
                                          lane[2].bus.out_last, lane[2].bus.out_data}), 64'd0);
    checkOutput({name, "_sd_lat3"}, 64'(lane[2].sending_data), 64'd0);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_lat1"}, 64'({lane[0].bus.out_valid, lane[0].sending_data[0]}), 64'd0);
    checkOutput({name, "_lat2"}, 64'({lane[1].bus.out_valid, lane[1].sending_data[0]}), 64'd0);
    checkOutput({name, "_lat3"}, 64'({lane[2].bus.out_valid, lane[2].sending_data[0]}), 64'd0);
  endtask

  initial begin
    int  n;
    int  base;
    bit  reached;

    user_rst  = 1'b1;
    dump_trig = 1'b0;
    repeat (3) @(posedge user_clk);
    #2;
    checkResetAll("reset");
    @(posedge user_clk);
    #1 user_rst = 1'b0;
    repeat (3) @(posedge user_clk);

    // Nominal dump, ready always high.
    ready_mode = 0;
    applyStimulus(1'b1, 1'b1);
    n = trig_cyc;
    waitIdle("nominal_done", 200);
    checkTiming(n);
    applyStimulus(1'b0, 1'b0);

    // Backpressure: ready one cycle in three.
    ready_mode = 1;
    applyStimulus(1'b1, 1'b1);
    n = trig_cyc;
    waitIdle("backpressure_done", 400);
    checkOutput("bp_rise_lat2", 64'(lane[1].rise_cyc), 64'(n + 1));
    applyStimulus(1'b0, 1'b0);
    ready_mode = 0;

    // Retrigger: extra edge mid-dump is dropped.
    applyStimulus(1'b1, 1'b1);
    n = trig_cyc;
    repeat (3) @(posedge user_clk);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge user_clk);
    applyStimulus(1'b1, 1'b0);
    waitIdle("retrig_done", 200);
    checkTiming(n);
`ifdef A2G_LUT_DUMP_CNT_EN
    checkOutput("cnt_after_three", 64'(lane[1].sending_data[31:16]), 64'd3);
`else
    checkOutput("upper_after_three", 64'(lane[1].sending_data[31:1]), 64'd0);
`endif

    // Trigger held high after completion: nothing new starts.
    repeat (30) @(posedge user_clk);
    #2;
    checkQuiet("held_trig_idle");

    // Low-to-high toggle: a second full dump from address 0.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    n = trig_cyc;
    waitIdle("toggle_done", 200);
    checkTiming(n);

    // Reset after the 5th handshake of the RD_LAT=2 lane.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    base    = lane[1].hs_count;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge user_clk);
      #2;
      reached = (lane[1].hs_count >= base + 5);
    end
    checkOutput("fifth_hs_reached", 64'(reached), 64'd1);
    user_rst = 1'b1;
    #1;
    checkResetAll("reset_mid");
    dump_trig = 1'b0;
    lane[0].exp_q.delete();
    lane[1].exp_q.delete();
    lane[2].exp_q.delete();
    repeat (2) @(posedge user_clk);
    #1 user_rst = 1'b0;
    repeat (10) @(posedge user_clk);
    #2;
    checkQuiet("post_reset_quiet");
    applyStimulus(1'b1, 1'b1);
    n = trig_cyc;
    waitIdle("restart_done", 200);
    checkTiming(n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
